// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Handshake bundle between the fetch unit, the fetch queue
//                and the decode stage.
//                Fetch side : F_valid, F_PC, F_Instr -> queue; F_ready <- queue
//                Decode side: D_ready -> queue; D_valid, D_PC, D_Instr <- queue
//                Control    : flush -> queue; count <- queue (occupancy)
//                modport master : environment (fetch + decode + redirect)
//                modport slave  : the fetch queue itself
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     F_valid;
  logic [31:0]              F_PC;
  logic [31:0]              F_Instr;
  logic                     F_ready;
  logic                     flush;
  logic                     D_ready;
  logic                     D_valid;
  logic [31:0]              D_PC;
  logic [31:0]              D_Instr;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output F_valid, F_PC, F_Instr, flush, D_ready,
    input  F_ready, D_valid, D_PC, D_Instr, count
  );

  modport slave (
    input  F_valid, F_PC, F_Instr, flush, D_ready,
    output F_ready, D_valid, D_PC, D_Instr, count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : DEPTH-entry circular queue of {PC, Instr} pairs decoupling
//                the instruction fetch unit from decode.
//  Ports       : clk   - system clock, rising edge
//                reset - asynchronous active-low reset
//                q     - fetch_queue_if.slave (fetch push, decode pop,
//                        flush, occupancy count)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  wire logic       clk,
  input  wire logic       reset,
  fetch_queue_if.slave    q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [63:0]    mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    last_pc_q, last_pc_d;

  logic           f_ready;
  logic           d_valid;
  logic           push;
  logic           pop;
  logic [63:0]    head;
  logic [31:0]    d_pc;

  // Handshake qualifiers depend only on registered occupancy, so F_ready
  // never has a combinational path from D_ready.
  assign f_ready = (count_q != C_FULL);
  assign d_valid = (count_q != '0);
  assign push    = q.F_valid & f_ready & ~q.flush;
  assign pop     = d_valid & q.D_ready;

  assign head    = mem_q[rd_ptr_q];
  // While empty, D_PC holds the PC of the last consumed instruction.
  assign d_pc    = d_valid ? head[63:32] : last_pc_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;

    // A pop in a flush cycle is still a consumed instruction.
    if (pop) begin
      last_pc_d = d_pc;
    end

    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= RESET_PC;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {q.F_PC, q.F_Instr};
    end
  end

  assign q.F_ready = f_ready;
  assign q.D_valid = d_valid;
  assign q.D_PC    = d_pc;
  assign q.D_Instr = d_valid ? head[31:0] : 32'h0000_0000;
  assign q.count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue (DEPTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  fetch_queue_if #(.DEPTH(DEPTH)) fq_if ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_3000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .q     (fq_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
    fq_if.F_valid = 1'b1;
    fq_if.F_PC    = pc;
    fq_if.F_Instr = ins;
    step();
    fq_if.F_valid = 1'b0;
  endtask

  // Occupancy invariants on every falling edge out of reset.
  always @(negedge clk) begin
    if (reset) begin
      chk("inv_count_le_depth", {31'd0, (fq_if.count <= 3'(DEPTH))}, 32'd1);
      chk("inv_fready", {31'd0, fq_if.F_ready}, {31'd0, (fq_if.count != 3'(DEPTH))});
      chk("inv_dvalid", {31'd0, fq_if.D_valid}, {31'd0, (fq_if.count != 3'd0)});
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    fq_if.F_valid = 1'b0;
    fq_if.F_PC    = '0;
    fq_if.F_Instr = '0;
    fq_if.flush   = 1'b0;
    fq_if.D_ready = 1'b0;

    // Reset then idle
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst_dvalid", {31'd0, fq_if.D_valid}, 32'd0);
    chk("rst_fready", {31'd0, fq_if.F_ready}, 32'd1);
    chk("rst_count",  {29'd0, fq_if.count},   32'd0);
    chk("rst_dpc",    fq_if.D_PC,             32'h0000_3000);
    chk("rst_dinstr", fq_if.D_Instr,          32'h0000_0000);

    // Single pass
    push_one(32'h0000_3000, 32'h3C01_0001);
    chk("single_dvalid", {31'd0, fq_if.D_valid}, 32'd1);
    chk("single_dpc",    fq_if.D_PC,             32'h0000_3000);
    chk("single_dinstr", fq_if.D_Instr,          32'h3C01_0001);
    chk("single_count",  {29'd0, fq_if.count},   32'd1);
    fq_if.D_ready = 1'b1;
    step();
    fq_if.D_ready = 1'b0;
    chk("pop_count",  {29'd0, fq_if.count},   32'd0);
    chk("pop_dvalid", {31'd0, fq_if.D_valid}, 32'd0);
    chk("pop_dpc",    fq_if.D_PC,             32'h0000_3000);
    chk("pop_dinstr", fq_if.D_Instr,          32'h0000_0000);

    // Fill and stall
    for (int i = 0; i < 4; i++) push_one(32'h0000_3000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
    chk("full_count",  {29'd0, fq_if.count},   32'd4);
    chk("full_fready", {31'd0, fq_if.F_ready}, 32'd0);
    push_one(32'h0000_3010, 32'hDEAD_BEEF);
    chk("full_ignore_count", {29'd0, fq_if.count}, 32'd4);
    chk("full_head_pc",      fq_if.D_PC,           32'h0000_3000);
    chk("full_head_instr",   fq_if.D_Instr,        32'h1000_0000);
    fq_if.D_ready = 1'b1;
    step();
    fq_if.D_ready = 1'b0;
    chk("unfull_count",  {29'd0, fq_if.count},   32'd3);
    chk("unfull_fready", {31'd0, fq_if.F_ready}, 32'd1);
    chk("unfull_dpc",    fq_if.D_PC,             32'h0000_3004);

    // Wrap-around: bring count to 2, then push+pop for 10 cycles
    fq_if.D_ready = 1'b1;
    step();
    chk("wrap_start_count", {29'd0, fq_if.count}, 32'd2);
    chk("wrap_start_dpc",   fq_if.D_PC,           32'h0000_3008);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_dpc", fq_if.D_PC, 32'h0000_3008 + 32'(4 * i));
      fq_if.F_valid = 1'b1;
      fq_if.F_PC    = 32'h0000_3010 + 32'(4 * i);
      fq_if.F_Instr = 32'h2000_0000 + 32'(i);
      step();
      chk("wrap_count", {29'd0, fq_if.count}, 32'd2);
    end
    fq_if.F_valid = 1'b0;
    fq_if.D_ready = 1'b0;
    chk("wrap_end_dpc",   fq_if.D_PC,    32'h0000_3030);
    chk("wrap_end_instr", fq_if.D_Instr, 32'h2000_0008);

    // Flush: empty, refill to 3 with head 0x3000, then flush with push+pop
    fq_if.flush = 1'b1;
    step();
    fq_if.flush = 1'b0;
    chk("clr_count", {29'd0, fq_if.count}, 32'd0);
    for (int i = 0; i < 3; i++) push_one(32'h0000_3000 + 32'(4 * i), 32'h3000_0000 + 32'(i));
    chk("pre_flush_count", {29'd0, fq_if.count}, 32'd3);
    chk("pre_flush_dpc",   fq_if.D_PC,           32'h0000_3000);
    fq_if.flush   = 1'b1;
    fq_if.F_valid = 1'b1;
    fq_if.F_PC    = 32'h0000_3010;
    fq_if.F_Instr = 32'hCAFE_0001;
    fq_if.D_ready = 1'b1;
    step();
    fq_if.flush   = 1'b0;
    fq_if.F_valid = 1'b0;
    fq_if.D_ready = 1'b0;
    chk("flush_count",  {29'd0, fq_if.count},   32'd0);
    chk("flush_dvalid", {31'd0, fq_if.D_valid}, 32'd0);
    chk("flush_fready", {31'd0, fq_if.F_ready}, 32'd1);
    chk("flush_dpc",    fq_if.D_PC,             32'h0000_3000);
    push_one(32'h0000_4000, 32'h4000_0000);
    chk("post_flush_dpc",   fq_if.D_PC,           32'h0000_4000);
    chk("post_flush_count", {29'd0, fq_if.count}, 32'd1);

    // Simultaneous push+pop so last_pc moves off RESET_PC, then fill to 3
    fq_if.D_ready = 1'b1;
    push_one(32'h0000_4004, 32'h4000_0001);
    fq_if.D_ready = 1'b0;
    chk("pp_count", {29'd0, fq_if.count}, 32'd1);
    chk("pp_dpc",   fq_if.D_PC,           32'h0000_4004);
    push_one(32'h0000_4008, 32'h4000_0002);
    push_one(32'h0000_400C, 32'h4000_0003);
    chk("pre_arst_count", {29'd0, fq_if.count}, 32'd3);

    // Asynchronous reset between edges
    #3;
    reset = 1'b0;
    #1;
    chk("arst_count",  {29'd0, fq_if.count},   32'd0);
    chk("arst_dvalid", {31'd0, fq_if.D_valid}, 32'd0);
    chk("arst_fready", {31'd0, fq_if.F_ready}, 32'd1);
    chk("arst_dpc",    fq_if.D_PC,             32'h0000_3000);
    step();
    reset = 1'b1;
    push_one(32'h0000_5000, 32'h5000_0000);
    chk("post_arst_dpc",   fq_if.D_PC,           32'h0000_5000);
    chk("post_arst_instr", fq_if.D_Instr,        32'h5000_0000);
    chk("post_arst_count", {29'd0, fq_if.count}, 32'd1);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling instruction queue between the fetch unit (IFU) and the decode stage of the pipelined MIPS core.
- Buffers up to DEPTH {PC, Instr} pairs produced by fetch and presents the oldest pair to decode using a valid/ready handshake.
- F_ready drives the fetch unit's PC write-enable, so fetch stalls when the queue is full.
- flush discards all buffered instructions on a branch or jump redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- RESET_PC, 32'h0000_3000, value of D_PC after reset while empty.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears the queue immediately.
- F_valid  input  1  fetch presents a valid instruction this cycle.
- F_PC  input  32  PC of the presented instruction.
- F_Instr  input  32  presented instruction word.
- F_ready  output  1  queue can accept an entry; connects to fetch PC write-enable.
- flush  input  1  redirect; discard all queued entries.
- D_ready  input  1  decode accepts the head entry; 0 = decode stall.
- D_valid  output  1  head entry present.
- D_PC  output  32  PC of the head entry.
- D_Instr  output  32  head instruction word.
- count  output  clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage: DEPTH-entry circular buffer of 64-bit {PC, Instr}, with read pointer rd_ptr and write pointer wr_ptr, each clog2(DEPTH) bits wide. Pointers wrap modulo DEPTH with no skipped slot. count is held as a separate register.
- Reset (reset=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, last_pc=RESET_PC. Storage contents are not reset.
  - Outputs during and after reset: D_valid=0, F_ready=1, D_PC=RESET_PC, D_Instr=0, count=0.
- F_ready = (count != DEPTH). It is purely registered-state-derived; there is no combinational dependence on D_ready.
- push = F_valid & F_ready & ~flush.
  - Writes {F_PC, F_Instr} at wr_ptr, then wr_ptr++.
- pop = D_valid & D_ready.
  - rd_ptr++ and last_pc <= D_PC.
- D_valid = (count != 0).
  - When D_valid=1: D_PC and D_Instr are the entry at rd_ptr, read combinationally from storage.
  - When D_valid=0: D_Instr=32'h0000_0000 (nop) and D_PC=last_pc.
- Latency: an entry pushed at edge N is visible on D_* after edge N, regardless of prior emptiness. There is no same-cycle input-to-output bypass.
- Count update, when flush=0:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: unchanged.
- Full (count=DEPTH): F_ready=0, so F_valid is ignored. A pop in this cycle frees a slot, and F_ready rises the next cycle.
- Empty (count=0): D_valid=0. D_ready is ignored and no pop occurs.
- Flush (flush=1, highest priority):
  - Next state: rd_ptr=0, wr_ptr=0, count=0.
  - Any push in the same cycle is dropped.
  - A pop in the same cycle still counts as consumed, so last_pc updates to that head's PC.
  - Outputs after the flush edge: D_valid=0, F_ready=1.
- Reset asserted mid-operation clears all state asynchronously. The first post-reset push behaves exactly as from power-up.
- Invariants, checked by bench assertions:
  - 0 <= count <= DEPTH.
  - count == (wr_ptr - rd_ptr) mod DEPTH, except when count is DEPTH or 0 with equal pointers.
  - No push while count=DEPTH.
  - No pop while count=0.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then release -> D_valid=0, F_ready=1, count=0, D_PC=32'h0000_3000, D_Instr=0.
- Single pass: push {0x3000, 0x3C010001} with D_ready=0 -> the next cycle shows D_valid=1, D_PC=0x3000, D_Instr=0x3C010001, count=1. Then D_ready=1 for 1 cycle -> count=0, D_valid=0, D_PC=0x3000, D_Instr=0.
- Fill and stall: D_ready=0, push PCs 0x3000, 0x3004, 0x3008, 0x300C -> count=4, F_ready=0. A fifth F_valid is ignored. One pop -> F_ready=1 the next cycle, D_PC=0x3004.
- Wrap-around: push and pop simultaneously every cycle for 10 cycles, starting with count=2 -> count stays 2. D_PC sequence increments by 4 with no loss or duplication across pointer wrap.
- Flush: count=3 (head 0x3000), assert flush with F_valid=1 (PC 0x3010) and D_ready=1 -> the next cycle shows count=0, D_valid=0, D_PC=0x3000, and 0x3010 is not enqueued. Next push 0x4000 -> D_PC=0x4000.
- Async reset mid-stream: count=3, drop reset between clock edges -> count=0, D_valid=0, F_ready=1 before the next rising edge.
